// File: rtl/data_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl_if -- host request / read-return bus of data_mem_ctrl.
//
// Signals:
//   host_valid  host -> ctrl  request valid
//   host_wr     host -> ctrl  1 = write, 0 = read
//   host_addr   host -> ctrl  byte address (upper bits beyond ADDR_W ignored)
//   host_wdata  host -> ctrl  write data
//   host_ready  ctrl -> host  controller accepts requests (IDLE only)
//   host_rvalid ctrl -> host  one-cycle pulse, read data valid
//   host_rdata  ctrl -> host  read data
//
// Modports: master (host side), slave (controller side).
// ---------------------------------------------------------------------------
interface data_mem_ctrl_if;
  logic        host_valid;
  logic        host_wr;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ready;
  logic        host_rvalid;
  logic [7:0]  host_rdata;

  modport master (
    output host_valid, host_wr, host_addr, host_wdata,
    input  host_ready, host_rvalid, host_rdata
  );

  modport slave (
    input  host_valid, host_wr, host_addr, host_wdata,
    output host_ready, host_rvalid, host_rdata
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl -- byte-wide data memory shared between a core and a host.
//
// The host owns the memory while the controller is IDLE (preload / readback);
// the core owns it while RUN. DRAIN is a single cycle that lets a core write
// captured in the halt cycle commit before the host regains access.
//
// Core writes are split: address with dm_wr in cycle N, data on to_mem in
// cycle N+1 (commit). Core reads return one cycle after the address, with
// forwarding from a commit to the same address in that cycle.
//
// Ports:
//   clk       sole clock, rising edge
//   rst       synchronous, active-high reset (memory contents are kept)
//   addr_dm   core address (low ADDR_W bits used)
//   dm_wr     core write strobe, sampled with addr_dm
//   to_mem    core write data, one cycle after dm_wr (bits [7:0] stored)
//   dm_in     core read data
//   start     host pulse IDLE -> RUN
//   halt      host pulse RUN -> DRAIN
//   core_en   high in RUN
//   wr_count  committed core writes since reset, saturating
//   host      data_mem_ctrl_if.slave host request bus
//
// Configuration macro:
//   DATA_MEM_CTRL_HOST_RD_EN  compiles in the host read-return path. When
//   undefined, host reads are accepted but host_rvalid/host_rdata stay 0.
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      addr_dm,
  input  logic             dm_wr,
  input  logic [15:0]      to_mem,
  output logic [7:0]       dm_in,
  input  logic             start,
  input  logic             halt,
  output logic             core_en,
  output logic [15:0]      wr_count,
  data_mem_ctrl_if.slave   host
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [7:0]        mem [2**ADDR_W];

  logic [ADDR_W-1:0] core_addr;
  logic [ADDR_W-1:0] host_addr;
  logic [ADDR_W-1:0] pend_addr_q;
  logic              pend_q;

  logic              capture;
  logic              commit;
  logic              core_rd;
  logic              host_acc;
  logic              host_we;
  logic              host_re;

  // Upper address bits and to_mem[15:8] are intentionally dropped.
  logic              unused_bits;
  assign unused_bits = ^{addr_dm[15:ADDR_W], host.host_addr[15:ADDR_W], to_mem[15:8]};

  assign core_addr = addr_dm[ADDR_W-1:0];
  assign host_addr = host.host_addr[ADDR_W-1:0];

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;   // start wins over a coincident halt
      ST_RUN:   if (halt)  state_d = ST_DRAIN;
      ST_DRAIN:            state_d = ST_IDLE;
      default:             state_d = ST_IDLE;
    endcase
  end

  assign core_en         = (state_q == ST_RUN);
  assign host.host_ready = (state_q == ST_IDLE);

  // -------------------------------------------------------------------------
  // Core side
  // -------------------------------------------------------------------------
  // Capture only in RUN; a capture in the halt cycle commits during DRAIN.
  // A pending write always commits in RUN or DRAIN, never in IDLE, so it can
  // never collide with a host write. rst drops a pending write.
  assign capture = core_en & dm_wr;
  assign commit  = pend_q & ~rst;
  assign core_rd = core_en & ~dm_wr;

  always_ff @(posedge clk) begin
    if (rst) pend_q <= 1'b0;
    else     pend_q <= capture;
  end

  always_ff @(posedge clk) begin
    if (capture) pend_addr_q <= core_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dm_in <= 8'h00;
    end else if (core_rd) begin
      // Forward the data being committed this cycle to a same-address read.
      if (commit && (pend_addr_q == core_addr)) dm_in <= to_mem[7:0];
      else                                      dm_in <= mem[core_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                             wr_count <= 16'h0000;
    else if (commit && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
  end

  // -------------------------------------------------------------------------
  // Host side
  // -------------------------------------------------------------------------
  assign host_acc = host.host_valid & host.host_ready & ~rst;
  assign host_we  = host_acc &  host.host_wr;
  assign host_re  = host_acc & ~host.host_wr;

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  // NOTE: the array has no reset; contents must survive rst, and a reset
  // would also prevent mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (commit)       mem[pend_addr_q] <= to_mem[7:0];
    else if (host_we) mem[host_addr]   <= host.host_wdata;
  end

`ifdef DATA_MEM_CTRL_HOST_RD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      host.host_rvalid <= 1'b0;
      host.host_rdata  <= 8'h00;
    end else begin
      host.host_rvalid <= host_re;
      if (host_re) host.host_rdata <= mem[host_addr];
    end
  end
`else
  logic unused_host_re;
  assign unused_host_re   = host_re;
  assign host.host_rvalid = 1'b0;
  assign host.host_rdata  = 8'h00;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl -- directed self-checking bench for data_mem_ctrl.
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns after the
// edge that should have produced them.
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr_dm;
  logic        dm_wr;
  logic [15:0] to_mem;
  logic [7:0]  dm_in;
  logic        start;
  logic        halt;
  logic        core_en;
  logic [15:0] wr_count;

  int n_vec = 0;
  int n_err = 0;

  data_mem_ctrl_if host_if ();

  data_mem_ctrl #(.ADDR_W(12)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr_dm  (addr_dm),
    .dm_wr    (dm_wr),
    .to_mem   (to_mem),
    .dm_in    (dm_in),
    .start    (start),
    .halt     (halt),
    .core_en  (core_en),
    .wr_count (wr_count),
    .host     (host_if.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_req(input logic v, input logic w, input logic [15:0] a, input logic [7:0] d);
    host_if.host_valid = v;
    host_if.host_wr    = w;
    host_if.host_addr  = a;
    host_if.host_wdata = d;
  endtask

  initial begin
    rst = 1'b1; addr_dm = '0; dm_wr = 1'b0; to_mem = '0; start = 1'b0; halt = 1'b0;
    host_req(1'b0, 1'b0, 16'h0, 8'h0);
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_core_en",     16'(core_en), 16'h0);
    check("rst_host_ready",  16'(host_if.host_ready), 16'h1);
    check("rst_host_rvalid", 16'(host_if.host_rvalid), 16'h0);
    check("rst_host_rdata",  16'(host_if.host_rdata), 16'h0);
    check("rst_dm_in",       16'(dm_in), 16'h0);
    check("rst_wr_count",    wr_count, 16'h0);

    // Host preload 0x0010 <- A5, 0x0040 <- 3C, then read 0x0010
    host_req(1'b1, 1'b1, 16'h0010, 8'hA5); tick();
    host_req(1'b1, 1'b1, 16'h0040, 8'h3C); tick();
    host_req(1'b1, 1'b0, 16'h0010, 8'h00); tick();
`ifdef DATA_MEM_CTRL_HOST_RD_EN
    check("host_rd_rvalid", 16'(host_if.host_rvalid), 16'h1);
    check("host_rd_rdata",  16'(host_if.host_rdata), 16'h00A5);
`else
    check("host_rd_rvalid_off", 16'(host_if.host_rvalid), 16'h0);
    check("host_rd_rdata_off",  16'(host_if.host_rdata), 16'h0);
`endif
    host_req(1'b0, 1'b0, 16'h0, 8'h0); tick();
    check("host_rvalid_pulse", 16'(host_if.host_rvalid), 16'h0);

    // Enter RUN
    start = 1'b1; tick(); start = 1'b0;
    check("run_core_en",    16'(core_en), 16'h1);
    check("run_host_ready", 16'(host_if.host_ready), 16'h0);

    // Core write 0x0020; a host write in RUN must be dropped
    addr_dm = 16'h0020; dm_wr = 1'b1; to_mem = 16'h0099;
    host_req(1'b1, 1'b1, 16'h0010, 8'hFF); tick();
    check("capture_dm_in_hold", 16'(dm_in), 16'h0);
    host_req(1'b0, 1'b0, 16'h0, 8'h0);
    addr_dm = 16'h0010; dm_wr = 1'b0; to_mem = 16'h0037; tick();
    check("rd_0010_no_host_wr", 16'(dm_in), 16'h00A5);
    check("wr_count_1",         wr_count, 16'h1);
    addr_dm = 16'h0020; to_mem = 16'h0099; tick();
    check("rd_0020",            16'(dm_in), 16'h0037);

    // Forwarding: read 0x0020 in the commit cycle of 0x5A
    dm_wr = 1'b1; tick();
    dm_wr = 1'b0; to_mem = 16'h005A; tick();
    check("fwd_dm_in",   16'(dm_in), 16'h005A);
    check("wr_count_2",  wr_count, 16'h2);
    to_mem = 16'h0099; tick();
    check("fwd_stored",  16'(dm_in), 16'h005A);

    // Wrap with back-to-back writes: 0x1005 <- 77, 0x0006 <- 42
    addr_dm = 16'h1005; dm_wr = 1'b1; tick();
    addr_dm = 16'h0006; to_mem = 16'hAB77; tick();
    addr_dm = 16'h0005; dm_wr = 1'b0; to_mem = 16'h0042; tick();
    check("wrap_rd_0005", 16'(dm_in), 16'h0077);
    check("wr_count_4",   wr_count, 16'h4);
    addr_dm = 16'h0006; to_mem = 16'h0099; tick();
    check("b2b_rd_0006",  16'(dm_in), 16'h0042);

    // Halt with a write captured in the same cycle
    addr_dm = 16'h0030; dm_wr = 1'b1; halt = 1'b1; tick();
    check("drain_core_en",    16'(core_en), 16'h0);
    check("drain_host_ready", 16'(host_if.host_ready), 16'h0);
    halt = 1'b0; dm_wr = 1'b0; to_mem = 16'h0011; addr_dm = 16'h0010;
    host_req(1'b1, 1'b0, 16'h0010, 8'h00); tick();
    check("idle_host_ready",  16'(host_if.host_ready), 16'h1);
    check("wr_count_5",       wr_count, 16'h5);
    check("drain_dm_in_hold", 16'(dm_in), 16'h0042);
    check("drain_host_rd_ignored", 16'(host_if.host_rvalid), 16'h0);

    // Host read 0x0030 in IDLE; a core dm_wr in IDLE must be ignored
    host_req(1'b1, 1'b0, 16'h0030, 8'h00);
    addr_dm = 16'h0030; dm_wr = 1'b1; to_mem = 16'h0099; tick();
`ifdef DATA_MEM_CTRL_HOST_RD_EN
    check("halt_host_rvalid", 16'(host_if.host_rvalid), 16'h1);
    check("halt_host_rdata",  16'(host_if.host_rdata), 16'h0011);
`else
    check("halt_host_rvalid_off", 16'(host_if.host_rvalid), 16'h0);
`endif
    host_req(1'b0, 1'b0, 16'h0, 8'h0);
    dm_wr = 1'b0; to_mem = 16'h00EE; tick();
    check("idle_dm_wr_ignored", wr_count, 16'h5);

    // start+halt together in IDLE -> RUN, halt ignored
    start = 1'b1; halt = 1'b1; tick();
    start = 1'b0; halt = 1'b0;
    check("start_halt_run", 16'(core_en), 16'h1);
    addr_dm = 16'h0030; tick();
    check("still_run",      16'(core_en), 16'h1);
    check("rd_0030",        16'(dm_in), 16'h0011);

    // Reset with a write pending (start asserted too; rst wins)
    addr_dm = 16'h0040; dm_wr = 1'b1; tick();
    rst = 1'b1; start = 1'b1; dm_wr = 1'b0; to_mem = 16'h0066; tick();
    rst = 1'b0; start = 1'b0;
    check("rst2_core_en",    16'(core_en), 16'h0);
    check("rst2_host_ready", 16'(host_if.host_ready), 16'h1);
    check("rst2_wr_count",   wr_count, 16'h0);
    check("rst2_dm_in",      16'(dm_in), 16'h0);
    start = 1'b1; tick(); start = 1'b0;
    addr_dm = 16'h0040; tick();
    check("rst2_pending_dropped", 16'(dm_in), 16'h003C);
    addr_dm = 16'h0020; tick();
    check("rst2_mem_kept",        16'(dm_in), 16'h005A);
    check("rst2_wr_count_idle",   wr_count, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
